// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass and a per-register
// busy scoreboard; read data and busy flags are registered (latency 1).
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRD-1:0]           rd_en,
  input  logic [NRD*ADDR_W-1:0]    rd_addr,
  output logic [NRD*DATA_W-1:0]    rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR*ADDR_W-1:0]    wr_addr,
  input  logic [NWR*DATA_W-1:0]    wr_data,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     mem_d [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic [NRD*DATA_W-1:0] rd_data_q;
  logic [NRD*DATA_W-1:0] rd_data_d;
  logic [NRD-1:0]        rd_busy_q;
  logic [NRD-1:0]        rd_busy_d;

  // Address 0 is hardwired when the zero register is enabled.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Post-update storage and scoreboard: later write ports override earlier
  // ones, and a mark is applied last so it wins over a clearing write.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int unsigned w = 0; w < NWR; w++) begin
      if (wr_en[w] && !is_zero(wr_addr[w*ADDR_W +: ADDR_W])) begin
        mem_d[wr_addr[w*ADDR_W +: ADDR_W]]  = wr_data[w*DATA_W +: DATA_W];
        busy_d[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (mark_en && !is_zero(mark_addr)) begin
      busy_d[mark_addr] = 1'b1;
    end
  end

  // Reads sample the post-update view, which gives the write bypass for free.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    for (int unsigned r = 0; r < NRD; r++) begin
      if (rd_en[r]) begin
        if (is_zero(rd_addr[r*ADDR_W +: ADDR_W])) begin
          rd_data_d[r*DATA_W +: DATA_W] = '0;
          rd_busy_d[r]                  = 1'b0;
        end else begin
          rd_data_d[r*DATA_W +: DATA_W] = mem_d[rd_addr[r*ADDR_W +: ADDR_W]];
          rd_busy_d[r]                  = busy_d[rd_addr[r*ADDR_W +: ADDR_W]];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp at default parameters.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        mark_en;
  logic [4:0]  mark_addr;

  int errors = 0;
  int checks = 0;

  regfile_mp dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mark_en   (mark_en),
    .mark_addr (mark_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_en   = '0;
    wr_en   = '0;
    mark_en = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*5 +: 5]   = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    rd_en[p]          = 1'b1;
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic mark(input logic [4:0] a);
    mark_en   = 1'b1;
    mark_addr = a;
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0; wr_addr = '0; wr_data = '0; mark_addr = '0;
    idle();
    tick();
    chk("reset_rd_data0", rd_data[31:0], 32'h0);
    chk("reset_rd_data1", rd_data[63:32], 32'h0);
    chk("reset_rd_busy", 32'(rd_busy), 32'h0);
    rst = 1'b0;

    // Write then read r5
    wr(0, 5'd5, 32'hDEADBEEF);
    tick(); idle();
    rd(0, 5'd5);
    tick(); idle();
    chk("wr_then_rd_r5", rd_data[31:0], 32'hDEADBEEF);

    // Dual write to r7 with same-cycle bypass on both read ports
    wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22);
    rd(0, 5'd7); rd(1, 5'd7);
    tick(); idle();
    chk("bypass_prio_p0", rd_data[31:0], 32'h22);
    chk("bypass_prio_p1", rd_data[63:32], 32'h22);
    rd(1, 5'd7);
    tick(); idle();
    chk("prio_stored_r7", rd_data[63:32], 32'h22);

    // Zero register ignores write and mark
    wr(0, 5'd0, 32'hFFFFFFFF); mark(5'd0); rd(0, 5'd0);
    tick(); idle();
    chk("r0_bypass_data", rd_data[31:0], 32'h0);
    chk("r0_bypass_busy", 32'(rd_busy[0]), 32'h0);
    rd(0, 5'd0);
    tick(); idle();
    chk("r0_later_data", rd_data[31:0], 32'h0);
    chk("r0_later_busy", 32'(rd_busy[0]), 32'h0);

    // Scoreboard on r3
    mark(5'd3);
    tick(); idle();
    rd(0, 5'd3);
    tick(); idle();
    chk("sb_mark_busy", 32'(rd_busy[0]), 32'h1);
    chk("sb_mark_data", rd_data[31:0], 32'h0);
    wr(1, 5'd3, 32'h5); rd(0, 5'd3);
    tick(); idle();
    chk("sb_clear_busy", 32'(rd_busy[0]), 32'h0);
    chk("sb_clear_data", rd_data[31:0], 32'h5);
    wr(0, 5'd3, 32'h6); mark(5'd3); rd(0, 5'd3);
    tick(); idle();
    chk("sb_markwins_busy", 32'(rd_busy[0]), 32'h1);
    chk("sb_markwins_data", rd_data[31:0], 32'h6);
    rd(1, 5'd3);
    tick(); idle();
    chk("sb_still_busy", 32'(rd_busy[1]), 32'h1);

    // Read hold while r9 changes
    wr(0, 5'd9, 32'h1);
    tick(); idle();
    rd(0, 5'd9);
    tick(); idle();
    chk("hold_initial", rd_data[31:0], 32'h1);
    wr(0, 5'd9, 32'h2);
    tick(); idle();
    chk("hold_data", rd_data[31:0], 32'h1);
    chk("hold_busy", 32'(rd_busy[0]), 32'h0);
    rd(0, 5'd9);
    tick(); idle();
    chk("hold_release", rd_data[31:0], 32'h2);

    // Top address, no aliasing with r1
    wr(0, 5'd31, 32'hA5A5A5A5); wr(1, 5'd1, 32'h1);
    tick(); idle();
    rd(0, 5'd31); rd(1, 5'd1);
    tick(); idle();
    chk("addr31", rd_data[31:0], 32'hA5A5A5A5);
    chk("addr1", rd_data[63:32], 32'h1);

    // Mid-cycle reset with in-flight write and mark
    wr(0, 5'd4, 32'h44); mark(5'd4); rd(0, 5'd4);
    rst = 1'b1;
    #2;
    chk("async_clear_data", rd_data[31:0], 32'h0);
    chk("async_clear_busy", 32'(rd_busy), 32'h0);
    tick(); idle();
    rst = 1'b0;
    for (int a = 1; a < 32; a++) begin
      rd(0, 5'(a)); rd(1, 5'(32 - a));
      tick(); idle();
      chk($sformatf("rst_sweep_data0_r%0d", a), rd_data[31:0], 32'h0);
      chk($sformatf("rst_sweep_data1_r%0d", 32 - a), rd_data[63:32], 32'h0);
      chk($sformatf("rst_sweep_busy_r%0d", a), 32'(rd_busy), 32'h0);
    end

    // First edge after reset release is live
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr(0, 5'd2, 32'h77); mark(5'd6); rd(0, 5'd2); rd(1, 5'd6);
    tick(); idle();
    chk("post_rst_first_data", rd_data[31:0], 32'h77);
    chk("post_rst_first_busy", 32'(rd_busy[1]), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 2, meaning number of write ports (1..2).
REQ-005 SHALL have parameter ZERO_REG, default 1, meaning address 0 reads as zero and ignores writes when 1.
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port rst  input  1  reset; one clock, asynchronous and active-high.
REQ-008 SHALL have port rd_en  input  NRD  per-port read enable.
REQ-009 SHALL have port rd_addr  input  NRD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port rd_data  output  NRD*DATA_W  registered read data, packed like rd_addr.
REQ-011 SHALL have port rd_busy  output  NRD  registered scoreboard busy flag per read port.
REQ-012 SHALL have port wr_en  input  NWR  per-port write enable.
REQ-013 SHALL have port wr_addr  input  NWR*ADDR_W  write addresses.
REQ-014 SHALL have port wr_data  input  NWR*DATA_W  write data.
REQ-015 SHALL have port mark_en  input  1  marks mark_addr busy (pending producer).
REQ-016 SHALL have port mark_addr  input  ADDR_W  register to mark busy.

Function
REQ-017 SHALL update storage on rising clk: for each port with wr_en=1, mem[wr_addr] <= wr_data.
REQ-018 SHALL, when two write ports target the same address in one cycle, store the higher-indexed port's data.
REQ-019 SHALL, with ZERO_REG=1, discard writes and marks to address 0; with ZERO_REG=0, address 0 is an ordinary register.
REQ-020 SHALL, for each read port with rd_en=1, load rd_data one cycle later (latency 1) with the post-write value of rd_addr.
REQ-021 SHALL bypass same-cycle writes: a write to rd_addr in the read cycle returns the new wr_data, with REQ-018 priority applied.
REQ-022 SHALL return 0 on rd_data for address 0 when ZERO_REG=1, regardless of writes.
REQ-023 SHALL hold rd_data and rd_busy unchanged for a port whose rd_en=0.
REQ-024 SHALL keep one busy bit per register: set by mark_en, cleared by any enabled write to that address.
REQ-025 SHALL, on a mark and a write to the same address in one cycle, leave the bit set (mark wins).
REQ-026 SHALL load rd_busy with the post-update busy bit of rd_addr, consistent with REQ-021.
REQ-027 SHALL report rd_busy=0 for address 0 when ZERO_REG=1.
REQ-028 SHALL support any number of read ports addressing the same register concurrently with identical results.
REQ-029 SHALL treat addresses as full range 0..2**ADDR_W-1 with no wrap or aliasing.

Reset
REQ-030 SHALL, while rst=1, asynchronously clear all registers, all busy bits, rd_data and rd_busy to 0.
REQ-031 SHALL ignore wr_en, mark_en and rd_en while rst=1; an assertion mid-operation discards in-flight writes and marks.
REQ-032 SHALL accept operations on the first rising clk after rst deasserts.

Verification
REQ-033 SHALL cover reset: rst pulse mid-stream, then read addresses 1..31 -> all rd_data=0, rd_busy=0.
REQ-034 SHALL cover write-then-read: write 0xDEADBEEF to r5, read r5 next cycle -> rd_data=0xDEADBEEF one cycle after rd_en.
REQ-035 SHALL cover bypass and priority: same cycle wr0 r7=0x11, wr1 r7=0x22, read r7 -> rd_data=0x22; later read -> 0x22.
REQ-036 SHALL cover zero register: write 0xFFFFFFFF to r0 and mark r0, read r0 -> rd_data=0, rd_busy=0.
REQ-037 SHALL cover scoreboard: mark r3 -> rd_busy=1; write r3=0x5 -> rd_busy=0, rd_data=0x5; mark and write r3 together -> rd_busy=1.
REQ-038 SHALL cover read hold: rd_en=0 while r9 changes 0x1 -> 0x2 -> rd_data stays at the prior value 0x1.
